// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: top-level game sequencing for a two-player pong.
// Tracks the game phases (idle, serve, play, point, game over), keeps score
// and tells the datapath when to move and when to recentre.
// Optional demo mode is compiled in with `define PONG_ATTRACT_EN.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       play_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner,
  output logic       attract
);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [6:0] SERVE_LAST = 7'(SERVE_FRAMES - 1);
  localparam logic [6:0] POINT_LAST = 7'(POINT_FRAMES - 1);

  state_t     state, state_nx;
  logic [6:0] frame_cnt;
  logic       btn_q;
  logic       start_pe;
  logic       restart;
  logic       enter;
  logic       scoring;
  logic [3:0] score_left_nx, score_right_nx;
  logic       serve_dir_nx, ball_reset_nx;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s < WIN) ? s + 4'd1 : s;
  endfunction

  assign start_pe = btn_start & ~btn_q;
  // A restart re-enters SERVE even from SERVE itself, so it must also clear the counter.
  assign enter    = (state_nx != state) || restart;

`ifdef PONG_ATTRACT_EN
  logic [2:0] idle_per;
  logic       idle_done;
  logic       attract_nx;

  assign scoring   = ~attract;
  // The 7-bit counter free-runs in IDLE; each wrap of its low six bits is one 64-frame period.
  assign idle_done = (state == IDLE) && frame_tick && (frame_cnt[5:0] == 6'd63) && (idle_per == 3'd7);

  // Demo-mode flag and the count of whole idle periods seen since entering IDLE.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      attract  <= 1'b0;
      idle_per <= '0;
    end else begin
      attract <= attract_nx;
      if (state != IDLE)
        idle_per <= '0;
      else if (frame_tick && frame_cnt[5:0] == 6'd63)
        idle_per <= idle_per + 3'd1;
    end
  end
`else
  assign scoring = 1'b1;
  assign attract = 1'b0;
`endif

  // Next-state, score and pulse decisions.
  always_comb begin
    state_nx       = state;
    score_left_nx  = score_left;
    score_right_nx = score_right;
    serve_dir_nx   = serve_dir;
    ball_reset_nx  = 1'b0;
    restart        = 1'b0;
`ifdef PONG_ATTRACT_EN
    attract_nx     = attract;
`endif
    unique case (state)
      IDLE: begin
        if (start_pe) restart = 1'b1;
`ifdef PONG_ATTRACT_EN
        else if (idle_done) begin
          attract_nx    = 1'b1;
          ball_reset_nx = 1'b1;
          state_nx      = SERVE;
        end
`endif
      end
      SERVE: begin
        if (attract && start_pe) restart = 1'b1;
        else if (frame_tick && frame_cnt == SERVE_LAST) state_nx = PLAY;
      end
      PLAY: begin
        if (attract && start_pe) restart = 1'b1;
        else if (miss_left && miss_right) begin
          ball_reset_nx = 1'b1;
          state_nx      = SERVE;
        end else if (miss_left) begin
          if (scoring) score_right_nx = sat_inc(score_right);
          serve_dir_nx = 1'b0;
          state_nx     = POINT;
        end else if (miss_right) begin
          if (scoring) score_left_nx = sat_inc(score_left);
          serve_dir_nx = 1'b1;
          state_nx     = POINT;
        end
      end
      POINT: begin
        if (attract && start_pe) restart = 1'b1;
        else if (frame_tick && frame_cnt == POINT_LAST) begin
          if (score_left == WIN || score_right == WIN) state_nx = OVER;
          else begin
            ball_reset_nx = 1'b1;
            state_nx      = SERVE;
          end
        end
      end
      OVER: begin
        if (start_pe) restart = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (restart) begin
      state_nx       = SERVE;
      score_left_nx  = '0;
      score_right_nx = '0;
      serve_dir_nx   = 1'b1;
      ball_reset_nx  = 1'b1;
`ifdef PONG_ATTRACT_EN
      attract_nx     = 1'b0;
`endif
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      btn_q       <= 1'b1;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b1;
      play_en     <= 1'b0;
      ball_reset  <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state       <= state_nx;
      btn_q       <= btn_start;
      frame_cnt   <= enter ? '0 : frame_cnt + {6'd0, frame_tick};
      score_left  <= score_left_nx;
      score_right <= score_right_nx;
      serve_dir   <= serve_dir_nx;
      ball_reset  <= ball_reset_nx;
      play_en     <= (state_nx == PLAY);
      game_over   <= (state_nx == OVER);
      winner      <= (state_nx == OVER) && (score_right_nx == WIN);
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scenarios with literal expectations followed by
// randomized play, all checked every cycle against a phase-level game model.
module tb_pong_game_ctrl;

  localparam int WIN = 7;
  localparam int SRV = 60;
  localparam int PNT = 30;

  logic       pclk = 1'b0;
  logic       rst_n, frame_tick, btn_start, miss_left, miss_right;
  logic       play_en, ball_reset, serve_dir, game_over, winner, attract;
  logic [3:0] score_left, score_right;

  int n_cmp = 0;
  int n_bad = 0;
  int br_cnt = 0;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SRV), .POINT_FRAMES(PNT)) dut (
    .pclk(pclk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_start(btn_start),
    .miss_left(miss_left), .miss_right(miss_right), .play_en(play_en),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .score_left(score_left),
    .score_right(score_right), .game_over(game_over), .winner(winner), .attract(attract)
  );

  always #5 pclk = ~pclk;

  // Game model: which phase the game is in and how many frames it has lasted.
  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;
  int phase, frames, m_sl, m_sr;
  bit m_prev, m_dir, m_br;

  task automatic go(input int p);
    phase  = p;
    frames = 0;
  endtask

  task automatic new_game();
    m_sl = 0; m_sr = 0; m_dir = 1'b1; m_br = 1'b1;
    go(P_SERVE);
  endtask

  always @(posedge pclk or negedge rst_n) begin
    bit pe;
    if (!rst_n) begin
      phase = P_IDLE; frames = 0; m_sl = 0; m_sr = 0;
      m_prev = 1'b1; m_dir = 1'b1; m_br = 1'b0;
    end else begin
      pe     = btn_start && !m_prev;
      m_prev = btn_start;
      m_br   = 1'b0;
      case (phase)
        P_IDLE, P_OVER: if (pe) new_game();
        P_SERVE: if (frame_tick) begin
          if (frames + 1 == SRV) go(P_PLAY); else frames++;
        end
        P_PLAY: begin
          if (miss_left && miss_right) begin m_br = 1'b1; go(P_SERVE); end
          else if (miss_left)  begin m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr; m_dir = 1'b0; go(P_POINT); end
          else if (miss_right) begin m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl; m_dir = 1'b1; go(P_POINT); end
        end
        P_POINT: if (frame_tick) begin
          if (frames + 1 == PNT) begin
            if (m_sl == WIN || m_sr == WIN) go(P_OVER);
            else begin m_br = 1'b1; go(P_SERVE); end
          end else frames++;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge pclk) begin
    logic [13:0] act, exp_v;
    if (rst_n === 1'b1) begin
      act   = {play_en, ball_reset, serve_dir, score_left, score_right, game_over, winner, attract};
      exp_v = {phase == P_PLAY, m_br, m_dir, 4'(m_sl), 4'(m_sr), phase == P_OVER,
               (phase == P_OVER) && (m_sr == WIN), 1'b0};
      n_cmp++;
      if (act !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, act, exp_v);
      end
    end
    if (ball_reset === 1'b1) br_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic drive(input bit b, input bit t, input bit ml, input bit mr);
    btn_start = b; frame_tick = t; miss_left = ml; miss_right = mr;
    @(negedge pclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(btn_start, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int b0;
    bit b;
    rst_n = 1'b0; btn_start = 1'b1; frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    repeat (3) @(negedge pclk);
    #1 rst_n = 1'b1;

    // Button held through reset must not start a game.
    repeat (10) drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("held_btn_play_en", play_en, 0);
    chk("held_btn_no_ball_reset", br_cnt, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_serve_dir", serve_dir, 1);
    chk("reset_scores", {score_left, score_right}, 0);

    // Start edge, then a full serve.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_ball_reset", ball_reset, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ball_reset_one_cycle", ball_reset, 0);
    ticks(SRV - 1);
    chk("serve_not_done", play_en, 0);
    ticks(1);
    chk("serve_done_play_en", play_en, 1);
    chk("single_start_pulse", br_cnt, 1);

    // Right miss scores for left.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("miss_right_score_left", score_left, 1);
    chk("miss_right_score_right", score_right, 0);
    chk("miss_right_dir", serve_dir, 1);
    chk("miss_right_play_off", play_en, 0);
    b0 = br_cnt;
    ticks(PNT - 1);
    chk("point_hold_no_pulse", br_cnt, b0);
    ticks(1);
    chk("point_end_ball_reset", ball_reset, 1);
    ticks(SRV);
    chk("reserve_play_en", play_en, 1);

    // Simultaneous misses: no score, reserve.
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("double_miss_ball_reset", ball_reset, 1);
    chk("double_miss_scores", {score_left, score_right}, 8'h10);
    chk("double_miss_play_off", play_en, 0);
    ticks(SRV);
    chk("double_miss_serve", play_en, 1);

    // Run left up to the winning score.
    repeat (5) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      ticks(PNT);
      ticks(SRV);
    end
    chk("score_left_six", score_left, 6);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("score_left_seven", score_left, 7);
    chk("not_over_yet", game_over, 0);
    ticks(PNT);
    chk("game_over", game_over, 1);
    chk("winner_left", winner, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("over_scores_held", {score_left, score_right}, 8'h70);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_scores", {score_left, score_right}, 0);
    chk("restart_game_over", game_over, 0);
    chk("restart_ball_reset", ball_reset, 1);
    ticks(SRV);
    chk("restart_serve", play_en, 1);

    // Randomized play with occasional mid-game resets.
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 7999) == 0) begin
        rst_n = 1'b0;
        drive(btn_start, 1'b0, 1'b0, 1'b0);
        drive(btn_start, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end
      b = ($urandom_range(0, 39) == 0) ? !btn_start : btn_start;
      drive(b, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7: points needed to win (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frames held in SERVE before play starts (1..127).
REQ-003 SHALL have parameter POINT_FRAMES, default 30: frames frozen after a point (1..127).
REQ-004 SHALL have ports as follows: one clock; reset is asynchronous and active-low.
- pclk  in  1  pixel clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- btn_start  in  1  start button, level, synchronous to pclk.
- miss_left  in  1  one-cycle pulse: ball passed the left paddle.
- miss_right  in  1  one-cycle pulse: ball passed the right paddle.
- play_en  out  1  enables ball and paddle motion in the datapath.
- ball_reset  out  1  one-cycle pulse: datapath recentres ball and paddles.
- serve_dir  out  1  0 = serve toward left, 1 = serve toward right.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- game_over  out  1  high while in OVER.
- winner  out  1  0 = left, 1 = right; valid while game_over.
- attract  out  1  demo-mode flag (see Configuration).

Function
REQ-005 SHALL implement FSM states IDLE, SERVE, PLAY, POINT, OVER.
REQ-006 SHALL register btn_start and act only on its rising edge (start_pe): btn_start=1 and previous sample=0.
REQ-007 SHALL use a 7-bit frame counter that counts frame_tick pulses and clears on every state entry.
REQ-008 IDLE: on start_pe, clear both scores, set serve_dir=1, pulse ball_reset, go to SERVE.
REQ-009 SERVE: hold play_en=0; when the counter reaches SERVE_FRAMES on a frame_tick, go to PLAY.
REQ-010 PLAY: play_en=1; miss_left alone increments score_right, sets serve_dir=0, and goes to POINT; miss_right alone increments score_left, sets serve_dir=1, and goes to POINT.
REQ-011 PLAY: miss_left and miss_right in the same cycle SHALL not change either score, keep serve_dir, pulse ball_reset, and go to SERVE.
REQ-012 POINT: play_en=0; when the counter reaches POINT_FRAMES, go to OVER if either score equals WIN_SCORE, else pulse ball_reset and go to SERVE.
REQ-013 OVER: game_over=1; winner=1 if score_right==WIN_SCORE, else 0; scores held; on start_pe, behave as REQ-008.
REQ-014 SHALL ignore miss_left/miss_right outside PLAY, and start_pe outside IDLE and OVER.
REQ-015 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-016 ball_reset SHALL be exactly one cycle wide and registered, asserted in the cycle after the triggering event.
REQ-017 play_en SHALL be registered and high only in PLAY; deasserted the cycle after a miss is accepted.
REQ-018 frame_tick coinciding with a state transition SHALL count toward the new state's counter as zero, not one.

Reset
REQ-019 rst_n low SHALL asynchronously force state=IDLE, counter=0, scores=0, serve_dir=1, play_en=0, ball_reset=0, game_over=0, winner=0, attract=0, and the btn_start history to 1.
REQ-020 Because the btn_start history resets to 1, a button held through reset SHALL NOT start a game.
REQ-021 Reset asserted mid-game SHALL abandon the game with no ball_reset pulse; the first pulse is issued on the next start.

Configuration
REQ-022 With macro PONG_ATTRACT_EN defined: after 8 consecutive 64-frame periods in IDLE with no start_pe, the block SHALL set attract=1, pulse ball_reset, and run SERVE/PLAY/POINT with scores frozen at 0; start_pe in any attract state clears attract and behaves as REQ-008.
REQ-023 Without PONG_ATTRACT_EN: attract SHALL be tied to 0, and IDLE is left only by start_pe.

Verification
REQ-024 Reset, btn_start held high during and after reset -> state stays IDLE, play_en=0, no ball_reset pulse.
REQ-025 start_pe, then 60 frame_ticks -> one ball_reset pulse one cycle after the start edge; play_en rises after the 60th tick.
REQ-026 In PLAY, miss_right pulse -> score_left=1, serve_dir=1, play_en=0 next cycle; after 30 ticks, ball_reset pulse and state SERVE.
REQ-027 In PLAY, miss_left and miss_right in the same cycle -> scores unchanged, one ball_reset pulse, state SERVE.
REQ-028 score_left=6, miss_right, then 30 ticks -> score_left=7, game_over=1, winner=0; further miss pulses leave scores unchanged; start_pe clears scores and enters SERVE.
REQ-029 PONG_ATTRACT_EN defined, idle for 512 ticks -> attract=1 and ball_reset pulse; start_pe -> attract=0, scores 0, state SERVE.
